// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin write-back arbiter for one register file write port (optional lock: WB_ARB_LOCK_EN)
module wb_port_arbiter #(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 64,
    parameter int ADDR_W       = 5,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef WB_ARB_LOCK_EN
    input  logic [NREQ-1:0]         req_lock,
`endif
    input  logic                    port_stall,
    output logic                    wr_en_n,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [WIDTH-1:0]        wr_data,
    output logic [NREQ-1:0]         grant_q,
    output logic                    busy
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win_idx;
    logic              win_found;
    logic [PTR_W:0]    cand;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [WIDTH-1:0]  win_data;
    logic [PTR_W-1:0]  ptr_next;

`ifdef WB_ARB_LOCK_EN
    logic [1:0]        lock_cnt;
    logic [PTR_W-1:0]  lock_owner;
    logic [1:0]        lock_prev;
    logic [1:0]        lock_cnt_next;
`endif

    // Round-robin search from ptr upward, wrapping; the first valid requester gets ready
    always_comb begin
        req_ready = '0;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        if (rst && !port_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(NREQ)) begin
                    cand = cand - (PTR_W+1)'(NREQ);
                end
                if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[PTR_W-1:0];
                end
            end
            if (win_found) begin
                req_ready[win_idx] = 1'b1;
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = req_data[win_idx*WIDTH +: WIDTH];
    assign busy     = (|req_valid) | ~wr_en_n;

`ifdef WB_ARB_LOCK_EN
    // A locked winner keeps priority for up to four consecutive accepts, then yields
    always_comb begin
        lock_prev     = (lock_owner == win_idx) ? lock_cnt : 2'd0;
        lock_cnt_next = 2'd0;
        ptr_next      = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
        if (req_lock[win_idx] && lock_prev != 2'd3) begin
            ptr_next      = win_idx;
            lock_cnt_next = lock_prev + 2'd1;
        end
    end

    // Lock run tracking; only an accept changes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_cnt   <= 2'd0;
            lock_owner <= '0;
        end else if (accept) begin
            lock_cnt   <= lock_cnt_next;
            lock_owner <= win_idx;
        end
    end
`else
    // Plain rotation: the slot after the winner gets first look next time
    always_comb begin
        ptr_next = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
`endif

    // Pointer advances only on an accepted beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    // Output beat register; a stall freezes it so the pending write is re-presented
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_n <= 1'b1;
            wr_addr <= '0;
            wr_data <= '0;
            grant_q <= '0;
        end else if (!port_stall) begin
            if (accept) begin
                wr_addr <= win_addr;
                wr_data <= win_data;
                grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                wr_en_n <= (ZERO_DISCARD != 0) && (win_addr == '0);
            end else begin
                wr_en_n <= 1'b1;
                grant_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_data;
`ifdef WB_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic                   port_stall;
    logic                   wr_en_n;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREQ-1:0]        grant_q;
    logic                   busy;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_DISCARD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
`ifdef WB_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .port_stall (port_stall),
        .wr_en_n    (wr_en_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .grant_q    (grant_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*WIDTH +: WIDTH]   = d;
    endtask

    initial begin
        int w;
        rst        = 1'b0;
        port_stall = 1'b0;
        req_valid  = 4'b1111;
        req_addr   = '0;
        req_data   = '0;
`ifdef WB_ARB_LOCK_EN
        req_lock   = '0;
`endif
        for (int i = 0; i < NREQ; i++) set_beat(i, ADDR_W'(i + 1), 64'hA0 + 64'(i));

        // reset held for three cycles with every requester valid
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("rst_ready", req_ready, 4'b0000);
            tick();
            chk("rst_wr_en_n", wr_en_n, 1'b1);
            chk("rst_grant", grant_q, 4'b0000);
            chk("rst_addr", wr_addr, 5'd0);
            chk("rst_data", wr_data, 64'd0);
        end
        rst = 1'b1;
        #1;
        chk("first_ready", req_ready, 4'b0001);
        chk("busy_valid", busy, 1'b1);

        // all valid: rotation 0,1,2,3,0,1,2,3
        for (int n = 0; n < 8; n++) begin
            tick();
            w = n % 4;
            chk("rr_wr_en_n", wr_en_n, 1'b0);
            chk("rr_addr", wr_addr, 64'(w + 1));
            chk("rr_data", wr_data, 64'hA0 + 64'(w));
            chk("rr_grant", grant_q, 64'(1 << w));
        end

        // only requesters 1 and 3 valid
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            w = (n % 2 == 1) ? 3 : 1;
            #1;
            chk("alt_ready", req_ready, 64'(1 << w));
            tick();
            chk("alt_grant", grant_q, 64'(1 << w));
            chk("alt_addr", wr_addr, 64'(w + 1));
        end

        // stall over an output beat (addr 7, data DEAD); ptr is 0 here
        req_valid = 4'b0001;
        set_beat(0, 5'd7, 64'hDEAD);
        tick();
        chk("stl_pre_addr", wr_addr, 5'd7);
        set_beat(0, 5'd9, 64'hBEEF);
        port_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stl_ready", req_ready, 4'b0000);
            tick();
            chk("stl_wr_en_n", wr_en_n, 1'b0);
            chk("stl_addr", wr_addr, 5'd7);
            chk("stl_data", wr_data, 64'hDEAD);
            chk("stl_grant", grant_q, 4'b0001);
        end
        port_stall = 1'b0;
        #1;
        chk("rel_ready", req_ready, 4'b0001);
        chk("rel_commit_addr", wr_addr, 5'd7);
        tick();
        chk("b2b_wr_en_n", wr_en_n, 1'b0);
        chk("b2b_addr", wr_addr, 5'd9);
        chk("b2b_data", wr_data, 64'hBEEF);

        // zero-address beat from requester 2 is accepted but not written
        req_valid = 4'b0100;
        set_beat(2, 5'd0, 64'h55);
        #1;
        chk("zd_ready", req_ready, 4'b0100);
        tick();
        chk("zd_grant", grant_q, 4'b0100);
        chk("zd_wr_en_n", wr_en_n, 1'b1);
        chk("zd_data", wr_data, 64'h55);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", req_ready, 4'b0000);
        tick();
        chk("idle_wr_en_n", wr_en_n, 1'b1);
        chk("idle_grant", grant_q, 4'b0000);
        chk("idle_hold_data", wr_data, 64'h55);
        chk("idle_busy", busy, 1'b0);

        // reset while a beat is in flight; ptr is 3 here
        req_valid = 4'b1000;
        tick();
        chk("mid_wr_en_n", wr_en_n, 1'b0);
        chk("mid_grant", grant_q, 4'b1000);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 4'b0000);
        tick();
        chk("mid_rst_wr_en_n", wr_en_n, 1'b1);
        chk("mid_rst_grant", grant_q, 4'b0000);
        rst = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_ptr0", req_ready, 4'b0001);

`ifdef WB_ARB_LOCK_EN
        // requester 0 locked with everyone valid: 0,0,0,0,1,2,3,0
        req_valid = 4'b1111;
        req_lock  = 4'b0001;
        for (int n = 0; n < 8; n++) begin
            case (n)
                4: w = 1;
                5: w = 2;
                6: w = 3;
                default: w = 0;
            endcase
            tick();
            chk("lock_grant", grant_q, 64'(1 << w));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
